// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared codes for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        PHC_RUN      = 1'b0,
        PHC_MEM_WAIT = 1'b1
    } phc_state_t;

    localparam int DEST_SRC_W = 2;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU = 2'd0;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM = 2'd1;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_PC  = 2'd2;

    localparam int MEM_OP_W = 2;
    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_STORE = 2'd2;

    function automatic logic is_load_src(input logic [DEST_SRC_W-1:0] dest_src);
        return dest_src == DEST_SRC_MEM;
    endfunction

endpackage

// File: rtl/pipe_stage_shadow.sv
// rtl/pipe_stage_shadow.sv - enable/clear register holding one stage's control fields
module pipe_stage_shadow #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         q_valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (en) begin
            q_valid <= d_valid && !clr;
            q       <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush/redirect sequencing for the 5-stage core
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DEST_SRC_W-1:0] id_dest_src,
    input  logic [MEM_OP_W-1:0]   id_mem_op,
    input  logic                  id_branch_op,
    input  logic                  ex_branch_taken,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_bubble,
    output logic                  pc_redirect,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Shadow layout: {rd, is_load, mem_op, branch_op}
    localparam int SW   = REG_ADDR_W + MEM_OP_W + 2;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    logic                  ex_valid, mem_valid;
    logic [SW-1:0]         id_fields, ex_fields, mem_fields;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_load, ex_branch_op;
    logic [MEM_OP_W-1:0]   mem_op;
    logic                  mw, br, lu, br_win, lu_win;
    logic                  shadow_unused;
    phc_state_t            state, state_next;
    logic [WC_W-1:0]       wait_cnt;
    logic                  mem_err_q;
    logic [CNT_W-1:0]      stall_cnt_q;

    assign id_fields    = {id_rd, is_load_src(id_dest_src), id_mem_op, id_branch_op};
    assign ex_rd        = ex_fields[SW-1 -: REG_ADDR_W];
    assign ex_is_load   = ex_fields[MEM_OP_W+1];
    assign ex_branch_op = ex_fields[0];
    assign mem_op       = mem_fields[MEM_OP_W:1];
    assign shadow_unused = ^{mem_fields[SW-1:MEM_OP_W+1], mem_fields[0]};

    assign mw = mem_valid && (mem_op != MEM_OP_NOP) && !mem_ready;
    assign br = ex_valid && ex_branch_op && ex_branch_taken;
    assign lu = id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    assign br_win = br && !mw;
    assign lu_win = lu && !mw && !br;

    pipe_stage_shadow #(.W(SW)) u_ex_shadow (
        .clk     (clk),
        .rst     (rst),
        .en      (!mw),
        .clr     (br || lu),
        .d_valid (id_valid),
        .d       (id_fields),
        .q_valid (ex_valid),
        .q       (ex_fields)
    );

    pipe_stage_shadow #(.W(SW)) u_mem_shadow (
        .clk     (clk),
        .rst     (rst),
        .en      (!mw),
        .clr     (1'b0),
        .d_valid (ex_valid),
        .d       (ex_fields),
        .q_valid (mem_valid),
        .q       (mem_fields)
    );

    // Outputs are forced low while rst is held, even before the registers clear
    assign pc_stall      = !rst && (mw || lu_win);
    assign if_id_stall   = !rst && (mw || lu_win);
    assign if_id_flush   = !rst && br_win;
    assign id_ex_stall   = !rst && mw;
    assign id_ex_bubble  = !rst && (br_win || lu_win);
    assign ex_mem_stall  = !rst && mw;
    assign mem_wb_bubble = !rst && mw;
    assign pc_redirect   = !rst && br_win;
    assign mem_err       = !rst && mem_err_q;
    assign stall_cnt     = rst ? '0 : stall_cnt_q;

    always_comb begin
        state_next = state;
        case (state)
            PHC_RUN:      if (mw) state_next = PHC_MEM_WAIT;
            PHC_MEM_WAIT: if (mem_ready) state_next = PHC_RUN;
            default:      state_next = PHC_RUN;
        endcase
    end

    // wait_cnt counts consecutive wait cycles, the first one included
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PHC_RUN;
            wait_cnt    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_next;
            if (mw) begin
                if (wait_cnt != WC_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WC_W'(1);
                if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) mem_err_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (pc_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic [1:0] ds;
        logic [1:0] mop;
        logic       bop;
    } instr_t;

    typedef struct {
        logic [7:0]  ctrl;
        logic        err;
        logic [31:0] cnt;
        string       nm;
    } exp_t;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble, pc_redirect}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_BR   = 8'b0010_1001;
    localparam logic [7:0] C_MW   = 8'b1101_0110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic [1:0]  id_dest_src = '0, id_mem_op = '0;
    logic        id_branch_op = 1'b0, ex_branch_taken = 1'b0, mem_ready = 1'b1;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
    logic        ex_mem_stall, mem_wb_bubble, pc_redirect, mem_err;
    logic [31:0] stall_cnt;

    exp_t        exp_q[$];
    exp_t        m_e;
    logic [7:0]  m_ctrl;
    logic [31:0] exp_total = '0;
    int          n_pass = 0, n_total = 0, n_drain_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_dest_src(id_dest_src), .id_mem_op(id_mem_op), .id_branch_op(id_branch_op),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .pc_redirect(pc_redirect), .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    function automatic instr_t i_nop();
        instr_t i = '0;
        return i;
    endfunction

    function automatic instr_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i = '0;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.u1 = 1'b1;
        i.ds = DEST_SRC_MEM; i.mop = MEM_OP_LOAD;
        return i;
    endfunction

    function automatic instr_t i_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i = '0;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1;
        i.ds = DEST_SRC_ALU;
        return i;
    endfunction

    function automatic instr_t i_lui(input logic [4:0] rd, input logic [4:0] junk);
        instr_t i = '0;
        i.v = 1'b1; i.rd = rd; i.rs1 = junk; i.rs2 = junk; i.ds = DEST_SRC_ALU;
        return i;
    endfunction

    function automatic instr_t i_sw(input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i = '0;
        i.v = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1; i.mop = MEM_OP_STORE;
        return i;
    endfunction

    function automatic instr_t i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i = '0;
        i.v = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1; i.bop = 1'b1;
        return i;
    endfunction

    // One cycle: drive inputs after the edge and queue the expected response
    task automatic cyc(input instr_t ins, input logic taken, input logic mrdy, input logic r,
                       input logic [7:0] ec, input logic ee, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        id_valid = ins.v; id_rs1 = ins.rs1; id_rs2 = ins.rs2;
        id_rs1_used = ins.u1; id_rs2_used = ins.u2; id_rd = ins.rd;
        id_dest_src = ins.ds; id_mem_op = ins.mop; id_branch_op = ins.bop;
        ex_branch_taken = taken; mem_ready = mrdy;
        e.ctrl = ec;
        e.err  = r ? 1'b0 : ee;
        e.cnt  = r ? 32'd0 : exp_total;
        e.nm   = nm;
        exp_q.push_back(e);
        if (r) exp_total = '0;
        else if (ec[7] && exp_total != '1) exp_total = exp_total + 32'd1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                      id_ex_bubble, ex_mem_stall, mem_wb_bubble, pc_redirect};
            n_total++;
            if (m_ctrl === m_e.ctrl) n_pass++;
            else $display("FAIL %s ctrl: got %b want %b", m_e.nm, m_ctrl, m_e.ctrl);
            n_total++;
            if (mem_err === m_e.err) n_pass++;
            else $display("FAIL %s mem_err: got %b want %b", m_e.nm, mem_err, m_e.err);
            n_total++;
            if (stall_cnt === m_e.cnt) n_pass++;
            else $display("FAIL %s stall_cnt: got %0d want %0d", m_e.nm, stall_cnt, m_e.cnt);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        cyc(i_nop(), 0, 1, 1, C_NONE, 0, "reset");
        // load-use on rs1 and rs2; ALU dependence forwards without stalling
        cyc(i_lw(5'd5, 5'd1),            0, 1, 0, C_NONE, 0, "lw_issue");
        cyc(i_alu(5'd6, 5'd5, 5'd1),     0, 1, 0, C_LU,   0, "lu_stall");
        cyc(i_alu(5'd6, 5'd5, 5'd1),     0, 1, 0, C_NONE, 0, "lu_release");
        cyc(i_alu(5'd7, 5'd6, 5'd6),     0, 1, 0, C_NONE, 0, "alu_fwd");
        cyc(i_lw(5'd10, 5'd1),           0, 1, 0, C_NONE, 0, "lw10_issue");
        cyc(i_alu(5'd11, 5'd1, 5'd10),   0, 1, 0, C_LU,   0, "lu_rs2");
        cyc(i_alu(5'd11, 5'd1, 5'd10),   0, 1, 0, C_NONE, 0, "lu_rs2_release");
        // x0 destination and unused source never stall
        cyc(i_lw(5'd0, 5'd2),            0, 1, 0, C_NONE, 0, "lw_x0_issue");
        cyc(i_alu(5'd8, 5'd0, 5'd0),     0, 1, 0, C_NONE, 0, "lw_x0");
        cyc(i_lw(5'd9, 5'd2),            0, 1, 0, C_NONE, 0, "lw9_issue");
        cyc(i_lui(5'd12, 5'd9),          0, 1, 0, C_NONE, 0, "rs_unused");
        // taken and not-taken branch
        cyc(i_beq(5'd1, 5'd2),           0, 1, 0, C_NONE, 0, "beq_issue");
        cyc(i_alu(5'd12, 5'd1, 5'd1),    1, 1, 0, C_BR,   0, "br_taken");
        cyc(i_alu(5'd13, 5'd1, 5'd1),    1, 1, 0, C_NONE, 0, "br_one_cycle");
        cyc(i_beq(5'd1, 5'd2),           0, 1, 0, C_NONE, 0, "beq2_issue");
        cyc(i_nop(),                     0, 1, 0, C_NONE, 0, "br_not_taken");
        // store with three wait states
        cyc(i_sw(5'd3, 5'd4),            0, 1, 0, C_NONE, 0, "sw_issue");
        cyc(i_nop(),                     0, 1, 0, C_NONE, 0, "sw_to_mem");
        cyc(i_nop(),                     0, 0, 0, C_MW,   0, "mw_1");
        cyc(i_nop(),                     0, 0, 0, C_MW,   0, "mw_2");
        cyc(i_nop(),                     0, 0, 0, C_MW,   0, "mw_3");
        cyc(i_nop(),                     0, 1, 0, C_NONE, 0, "mw_done");
        cyc(i_nop(),                     0, 1, 0, C_NONE, 0, "cnt_after_mw");
        // wait overrides a taken branch, which redirects once the access completes
        cyc(i_sw(5'd3, 5'd4),            0, 1, 0, C_NONE, 0, "sw2_issue");
        cyc(i_beq(5'd1, 5'd2),           0, 1, 0, C_NONE, 0, "beq3_issue");
        cyc(i_nop(),                     1, 0, 0, C_MW,   0, "mw_over_br_1");
        cyc(i_nop(),                     1, 0, 0, C_MW,   0, "mw_over_br_2");
        cyc(i_nop(),                     1, 1, 0, C_BR,   0, "br_after_mw");
        cyc(i_nop(),                     0, 1, 0, C_NONE, 0, "after_br");
        // timeout, sticky error, reset mid-wait
        cyc(i_lw(5'd14, 5'd1),           0, 1, 0, C_NONE, 0, "lw14_issue");
        cyc(i_nop(),                     0, 1, 0, C_NONE, 0, "lw14_to_mem");
        for (int w = 1; w <= 64; w++)
            cyc(i_nop(), 0, 0, 0, C_MW, 0, $sformatf("wait_%0d", w));
        cyc(i_nop(),                     0, 0, 0, C_MW,   1, "timeout_set");
        cyc(i_nop(),                     0, 0, 0, C_MW,   1, "timeout_sticky");
        cyc(i_nop(),                     0, 0, 1, C_NONE, 0, "rst_mid_wait");
        cyc(i_nop(),                     0, 0, 0, C_NONE, 0, "run_after_rst");
        cyc(i_nop(),                     0, 1, 0, C_NONE, 0, "idle_after_rst");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_drain_fail = 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total + n_drain_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
